// File: rtl/mig_ui_burst_tester.sv
// Write/read-back traffic engine for the MIG 7-series app_* user interface.
// Latency: first app_en the cycle after start is sampled; done the cycle after the last read beat.
// Backpressure: app_en/app_wdf_wren and their payloads hold until app_rdy/app_wdf_rdy accept them.
//
// Ports:
//   clk, sys_rst             : MIG ui_clk, asynchronous active-high reset
//   start                    : single-cycle run request (needs init_calib_complete)
//   app_rdy / app_wdf_rdy    : MIG command / write-data ready
//   app_rd_data(_valid)      : MIG read return
//   app_en/app_cmd/app_addr  : command channel (000 write, 001 read)
//   app_wdf_*                : write-data channel, one beat per command, mask tied 0
//   busy/done/pass/timeout   : run status, held after done until the next start
//   err_count/first_err_addr : mismatch statistics of the last run
module mig_ui_burst_tester #(
  parameter int          ADDR_WIDTH     = 28,
  parameter int          DATA_WIDTH     = 512,
  parameter int          BURST_COUNT    = 16,
  parameter int          ADDR_STEP      = 8,
  parameter int          START_ADDR     = 0,
  parameter logic [31:0] PATTERN_SEED   = 32'h508050FF,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    init_calib_complete,
  input  logic                    app_rdy,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic                    timeout
);

  localparam int          LANES = DATA_WIDTH / 32;
  localparam int          WDW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] BC    = 16'(BURST_COUNT);
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE} state_t;

  state_t          state;
  logic [15:0]     wr_cmd_cnt, wr_dat_cnt, rd_cmd_cnt, rd_rcv_cnt;
  logic [WDW-1:0]  wd_cnt;
  logic [15:0]     err_next;
  logic            cmd_acc, dat_acc, rd_beat, mismatch, progress, running, abort, finish_ok;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] i);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++) p[k*32 +: 32] = (PATTERN_SEED + 32'(i)) ^ 32'(k);
    return p;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [15:0] i);
    logic [63:0] a;
    a = 64'(START_ADDR) + 64'(i) * 64'(ADDR_STEP);
    return a[ADDR_WIDTH-1:0];
  endfunction

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  assign cmd_acc  = app_en & app_rdy;
  assign dat_acc  = app_wdf_wren & app_wdf_rdy;
  assign running  = (state == S_WRITE) || (state == S_READ) || (state == S_WAIT_RD);
  // Surplus beats beyond BURST_COUNT are dropped without comparison.
  assign rd_beat  = app_rd_data_valid && ((state == S_READ) || (state == S_WAIT_RD)) && (rd_rcv_cnt != BC);
  assign mismatch = rd_beat && (app_rd_data != pattern(rd_rcv_cnt));
  assign progress = cmd_acc | dat_acc | rd_beat;
  // Watchdog fires after TIMEOUT_CYCLES consecutive cycles without any handshake.
  assign abort    = running && (!init_calib_complete ||
                                (!progress && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1))));
  // Finish on the cycle the last beat arrives so done shows one cycle later.
  assign finish_ok = (state == S_WAIT_RD) &&
                     ((rd_rcv_cnt == BC) || (rd_beat && (rd_rcv_cnt == BC - 16'd1)));

  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != 16'hFFFF)) err_next = err_count + 16'd1;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= S_IDLE;
      wr_cmd_cnt     <= '0;
      wr_dat_cnt     <= '0;
      rd_cmd_cnt     <= '0;
      rd_rcv_cnt     <= '0;
      wd_cnt         <= '0;
      app_en         <= 1'b0;
      app_cmd        <= CMD_WR;
      app_addr       <= '0;
      app_wdf_data   <= '0;
      app_wdf_wren   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      if (rd_beat) begin
        rd_rcv_cnt <= rd_rcv_cnt + 16'd1;
        err_count  <= err_next;
        if (mismatch && (err_count == 16'd0)) first_err_addr <= beat_addr(rd_rcv_cnt);
      end
      if (running) wd_cnt <= progress ? '0 : wd_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (start && init_calib_complete) begin
            state          <= S_WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            wr_cmd_cnt     <= '0;
            wr_dat_cnt     <= '0;
            rd_cmd_cnt     <= '0;
            rd_rcv_cnt     <= '0;
            wd_cnt         <= '0;
            app_en         <= 1'b1;
            app_cmd        <= CMD_WR;
            app_addr       <= beat_addr(16'd0);
            app_wdf_wren   <= 1'b1;
            app_wdf_data   <= pattern(16'd0);
          end
        end
        S_WRITE: begin
          // Command and data channels advance independently.
          if (cmd_acc) begin
            wr_cmd_cnt <= wr_cmd_cnt + 16'd1;
            if (wr_cmd_cnt + 16'd1 == BC) app_en <= 1'b0;
            else                          app_addr <= beat_addr(wr_cmd_cnt + 16'd1);
          end
          if (dat_acc) begin
            wr_dat_cnt <= wr_dat_cnt + 16'd1;
            if (wr_dat_cnt + 16'd1 == BC) app_wdf_wren <= 1'b0;
            else                          app_wdf_data <= pattern(wr_dat_cnt + 16'd1);
          end
          if ((wr_cmd_cnt == BC) && (wr_dat_cnt == BC)) begin
            state    <= S_READ;
            app_en   <= 1'b1;
            app_cmd  <= CMD_RD;
            app_addr <= beat_addr(16'd0);
          end
        end
        S_READ: begin
          if (cmd_acc) begin
            rd_cmd_cnt <= rd_cmd_cnt + 16'd1;
            if (rd_cmd_cnt + 16'd1 == BC) begin
              app_en <= 1'b0;
              state  <= S_WAIT_RD;
            end else begin
              app_addr <= beat_addr(rd_cmd_cnt + 16'd1);
            end
          end
        end
        S_WAIT_RD: ;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase

      // Completion and aborts share one exit; an abort outranks normal completion.
      if (abort || finish_ok) begin
        state        <= S_DONE;
        busy         <= 1'b0;
        done         <= 1'b1;
        pass         <= !abort && (err_next == 16'd0);
        timeout      <= abort;
        app_en       <= 1'b0;
        app_wdf_wren <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mig_ui_burst_tester.sv
// Scoreboard bench for mig_ui_burst_tester with a loop-back memory model.
// Expected commands, write beats and run results are queued by the stimulus;
// a negedge monitor pops and compares them as the DUT presents handshakes / done.
module tb_mig_ui_burst_tester;

  localparam int AW = 28;
  localparam int DW = 512;
  localparam int BC = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic          init_calib_complete = 1'b1;
  logic          app_rdy = 1'b0;
  logic          app_wdf_rdy = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  mig_ui_burst_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT(BC), .ADDR_STEP(8),
    .START_ADDR(0), .PATTERN_SEED(32'h508050FF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .init_calib_complete(init_calib_complete),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pass;
    logic          tmo;
    logic [15:0]   errs;
    logic [AW-1:0] faddr;
    int            nwc, nwd, nrc, to_delay;
  } res_t;

  res_t          exp_res[$];
  logic [AW-1:0] exp_wa[$], exp_ra[$], m_wa[$];
  logic [DW-1:0] exp_wd[$], m_wd[$], rdq[$];
  logic [31:0]   exp_l0[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] addr_tbl [BC];
  logic [31:0]   lane0_tbl [BC];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, run_cyc0 = 0, rdy_mode = 0, last_prog = 0;
  int nwc = 0, nwd = 0, nrc = 0;
  logic corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic done_q = 1'b0, pend_c = 1'b0, pend_d = 1'b0;
  logic [AW-1:0] pc_addr = '0;
  logic [2:0]    pc_cmd = '0;
  logic [DW-1:0] pd_data = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual=event occurred required=no such event", name);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] p;
    p = '0;
    for (int k = 0; k < DW / 32; k++) p[k*32 +: 32] = (32'h508050FF + 32'(i)) ^ 32'(k);
    return p;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready generator: 0 always ready, 1 toggling app_rdy + late app_wdf_rdy,
  // 2 refuse read commands, 3 nothing accepted.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
      1: begin app_rdy = cyc[0]; app_wdf_rdy = (cyc - run_cyc0) >= 4; end
      2: begin app_rdy = !(app_en && app_cmd == 3'b001); app_wdf_rdy = 1'b1; end
      default: begin app_rdy = 1'b0; app_wdf_rdy = 1'b0; end
    endcase
  end

  // Read return path: one beat per cycle, one cycle after the command.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdq.size() > 0) begin
      app_rd_data       = rdq.pop_front();
      app_rd_data_valid = 1'b1;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  // Monitor + memory model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (sys_rst) begin
      pend_c = 1'b0;
      pend_d = 1'b0;
      done_q = 1'b0;
    end else begin
      if (pend_c && !done) begin
        check("cmd_stable_en", 64'(app_en), 64'd1);
        check("cmd_stable_addr", 64'(app_addr), 64'(pc_addr));
        check("cmd_stable_cmd", 64'(app_cmd), 64'(pc_cmd));
      end
      if (pend_d && !done) begin
        check("wdf_stable_wren", 64'(app_wdf_wren), 64'd1);
        check("wdf_stable_data", 64'(app_wdf_data == pd_data), 64'd1);
      end
      pend_c  = app_en && !app_rdy;
      pc_addr = app_addr;
      pc_cmd  = app_cmd;
      pend_d  = app_wdf_wren && !app_wdf_rdy;
      pd_data = app_wdf_data;

      if (app_en && app_rdy) begin
        last_prog = cyc;
        if (app_cmd == 3'b000) begin
          nwc++;
          m_wa.push_back(app_addr);
          if (exp_wa.size() == 0) fail("wcmd_unexpected");
          else check("wcmd_addr", 64'(app_addr), 64'(exp_wa.pop_front()));
        end else if (app_cmd == 3'b001) begin
          logic [DW-1:0] d;
          nrc++;
          if (exp_ra.size() == 0) fail("rcmd_unexpected");
          else check("rcmd_addr", 64'(app_addr), 64'(exp_ra.pop_front()));
          d = mem.exists(app_addr) ? mem[app_addr] : '0;
          if (corrupt_en && app_addr == corrupt_addr) d[0] = ~d[0];
          rdq.push_back(d);
        end else begin
          check("cmd_code", 64'(app_cmd), 64'd0);
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        last_prog = cyc;
        nwd++;
        m_wd.push_back(app_wdf_data);
        check("wdf_end", 64'(app_wdf_end), 64'd1);
        if (exp_wd.size() == 0) fail("wdat_unexpected");
        else begin
          check("wdat_lane0", 64'(app_wdf_data[31:0]), 64'(exp_l0.pop_front()));
          check("wdat_full", 64'(app_wdf_data == exp_wd.pop_front()), 64'd1);
        end
      end
      while (m_wa.size() > 0 && m_wd.size() > 0) mem[m_wa.pop_front()] = m_wd.pop_front();
      if (app_rd_data_valid) last_prog = cyc;

      if (done && !done_q) begin
        if (exp_res.size() == 0) fail("done_unexpected");
        else begin
          res_t r;
          r = exp_res.pop_front();
          check("pass", 64'(pass), 64'(r.pass));
          check("timeout", 64'(timeout), 64'(r.tmo));
          check("err_count", 64'(err_count), 64'(r.errs));
          check("first_err_addr", 64'(first_err_addr), 64'(r.faddr));
          check("busy_at_done", 64'(busy), 64'd0);
          check("n_wcmd", 64'(nwc), 64'(r.nwc));
          check("n_wdat", 64'(nwd), 64'(r.nwd));
          check("n_rcmd", 64'(nrc), 64'(r.nrc));
          if (r.tmo) begin
            check("app_en_after_abort", 64'(app_en), 64'd0);
            check("wren_after_abort", 64'(app_wdf_wren), 64'd0);
          end
          if (r.to_delay >= 0) check("timeout_latency", 64'(cyc - last_prog), 64'(r.to_delay));
        end
      end
      done_q = done;
    end
  end

  task automatic flush();
    exp_wa.delete(); exp_ra.delete(); exp_wd.delete(); exp_l0.delete();
    exp_res.delete(); m_wa.delete(); m_wd.delete(); rdq.delete();
    nwc = 0; nwd = 0; nrc = 0;
  endtask

  task automatic push_beats(input bit wr, input bit rd);
    for (int i = 0; i < BC; i++) begin
      if (wr) begin
        exp_wa.push_back(addr_tbl[i]);
        exp_wd.push_back(pat(i));
        exp_l0.push_back(lane0_tbl[i]);
      end
      if (rd) exp_ra.push_back(addr_tbl[i]);
    end
  endtask

  task automatic push_res(input logic p, input logic t, input logic [15:0] e,
                          input logic [AW-1:0] fa, input int a, input int b, input int c,
                          input int tod);
    res_t r;
    r.pass = p; r.tmo = t; r.errs = e; r.faddr = fa;
    r.nwc = a; r.nwd = b; r.nrc = c; r.to_delay = tod;
    exp_res.push_back(r);
  endtask

  task automatic do_start();
    run_cyc0 = cyc + 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual=no done after %0d cycles required=done", name, budget);
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_res.size() != 0) fail({name, "_result_missing"});
  endtask

  initial begin
    addr_tbl  = '{28'd0, 28'd8, 28'd16, 28'd24};
    lane0_tbl = '{32'h508050FF, 32'h50805100, 32'h50805101, 32'h50805102};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_app_en", 64'(app_en), 64'd0);
    check("rst_app_cmd", 64'(app_cmd), 64'd0);
    check("rst_app_addr", 64'(app_addr), 64'd0);
    check("rst_wren", 64'(app_wdf_wren), 64'd0);
    check("rst_wdata0", 64'(app_wdf_data[63:0]), 64'd0);
    check("rst_mask", 64'(app_wdf_mask[63:0]), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    sys_rst = 1'b0;

    // 1: clean run, always ready
    rdy_mode = 0;
    flush(); push_beats(1, 1); push_res(1, 0, 0, 0, BC, BC, BC, -1);
    do_start();
    check("busy_running", 64'(busy), 64'd1);
    wait_done("run_clean", 200);

    // 2: toggling app_rdy, late app_wdf_rdy, extra start while busy
    rdy_mode = 1;
    flush(); push_beats(1, 1); push_res(1, 0, 0, 0, BC, BC, BC, -1);
    do_start();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run_backpressure", 300);

    // 3: memory corrupts bit 0 of beat 2
    rdy_mode = 0;
    corrupt_en = 1'b1; corrupt_addr = 28'd16;
    flush(); push_beats(1, 1); push_res(0, 0, 16'd1, 28'd16, BC, BC, BC, -1);
    do_start();
    wait_done("run_corrupt", 200);
    corrupt_en = 1'b0;

    // 4: read commands never accepted -> watchdog
    rdy_mode = 2;
    flush(); push_beats(1, 0); push_res(0, 1, 0, 0, BC, BC, 0, TO + 1);
    do_start();
    wait_done("run_watchdog", 400);
    repeat (3) @(negedge clk);
    check("app_en_idle_after_wd", 64'(app_en), 64'd0);

    // 5: calibration lost mid-WRITE
    rdy_mode = 3;
    flush(); push_res(0, 1, 0, 0, 0, 0, 0, -1);
    do_start();
    repeat (4) @(posedge clk);
    #1 init_calib_complete = 1'b0;
    wait_done("run_calib_loss", 50);

    // 6: start while uncalibrated is ignored
    do_start();
    repeat (3) @(negedge clk);
    check("nocal_busy", 64'(busy), 64'd0);
    check("nocal_app_en", 64'(app_en), 64'd0);
    check("nocal_done_held", 64'(done), 64'd1);
    init_calib_complete = 1'b1;

    // 7: reset mid-READ
    rdy_mode = 0;
    flush(); push_beats(1, 1);
    do_start();
    begin
      int k;
      k = 0;
      while (!(app_en && app_cmd == 3'b001) && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("reached_read", 64'(app_en && app_cmd == 3'b001), 64'd1);
    end
    sys_rst = 1'b1;
    #1;
    check("midrst_app_en", 64'(app_en), 64'd0);
    check("midrst_app_cmd", 64'(app_cmd), 64'd0);
    check("midrst_app_addr", 64'(app_addr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    repeat (2) @(posedge clk);
    flush();
    #1 sys_rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (app_en || busy) seen++;
      end
      check("no_app_en_after_rst", 64'(seen), 64'd0);
    end

    // 8: clean run after reset
    flush(); push_beats(1, 1); push_res(1, 0, 0, 0, BC, BC, BC, -1);
    do_start();
    wait_done("run_after_rst", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
